bus_ctrl: RTL and testbench
===========================

// Module: bus_ctrl
// PURPOSE
//  Bus controller downstream of the CPU's MEM stage. Decodes cpu_bc_addr and
//  routes each access to the data RAM or to a memory-mapped IO page.
//  The IO page holds LED/switch registers, a 32-bit timer with compare IRQ,
//  and an 8-bit TX FIFO with a valid/ready drain port.
//  Read data returns on bc_cpu_data with 1-cycle latency, matching synchronous-RAM timing.
// PARAMETERS
//  RAM_AW      10            RAM word-address bits; RAM region = byte addr < 4*2**RAM_AW
//  IO_BASE     32'hFFFF_0000 IO page base; register offsets decoded from addr[4:2]
//  FIFO_AW     3             TX FIFO depth = 2**FIFO_AW entries
//  LED_W       16            LED register width
//  SW_W        16            switch input width
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       synchronous reset, active-low
//  cpu_bc_addr  in   32      byte address from CPU (ALU result)
//  cpu_bc_data  in   32      CPU write data
//  cpu_bc_rw    in   1       1 = write this cycle, 0 = read
//  bc_cpu_data  out  32      read data to CPU, valid 1 cycle after address
//  dram_addr    out  RAM_AW  RAM word address = cpu_bc_addr[RAM_AW+1:2]
//  dram_wdata   out  32      = cpu_bc_data
//  dram_we      out  1       cpu_bc_rw & RAM hit
//  dram_rdata   in   32      RAM read data, 1-cycle synchronous
//  led          out  LED_W   LED register
//  sw           in   SW_W    asynchronous switches
//  tx_data      out  8       FIFO head byte
//  tx_valid     out  1       FIFO non-empty
//  tx_ready     in   1       consumer accepts head when tx_valid & tx_ready
//  irq          out  1       = timer match flag
// BEHAVIOUR
//  - Decode: RAM hit if addr[31:RAM_AW+2]==0. IO hit if addr[31:5]==IO_BASE[31:5].
//    Any other address is unmapped: reads return 0, writes are ignored.
//  - IO map (offset): 0x00 LED RW; 0x04 SW RO; 0x08 TCNT RW; 0x0C TCMP RW;
//    0x10 STATUS; 0x14 TXDATA WO (reads 0); 0x18-0x1C read 0.
//  - STATUS: [0] match W1C; [1] full; [2] empty; [3] overflow W1C;
//    [FIFO_AW+4:4] count. All other bits read 0.
//  - Read path: capture decode select and IO read value at clk. Next cycle,
//    bc_cpu_data = RAM-selected ? dram_rdata : captured value. Reads have no side effects.
//  - sw passes through a 2-flop synchronizer; the SW read adds 2 cycles of input delay.
//  - Timer: TCNT increments every cycle and wraps FFFF_FFFF->0.
//    A write to TCNT loads the value that cycle and beats the increment.
//    When TCNT==TCMP, match sets (sticky). If set and W1C happen in the same cycle, set wins.
//  - FIFO: a TXDATA write pushes cpu_bc_data[7:0].
//    A push is accepted if count<2**FIFO_AW, or if a pop occurs in the same cycle while full.
//    Otherwise the byte is dropped and overflow sets.
//    Pop when tx_valid&tx_ready. A push while empty makes tx_valid rise the next cycle.
//    tx_data is stable while tx_valid & ~tx_ready. Pointers wrap modulo depth; count is FIFO_AW+1 bits.
//  - Reset (rst==0 at clk): bc_cpu_data=0, led=0, TCNT=0, TCMP=FFFF_FFFF,
//    match=0, overflow=0, FIFO empty (tx_valid=0, tx_data=0), sync flops=0, irq=0.
//    A reset mid-operation discards FIFO contents and any pending read.
//  - dram_* are combinational from cpu_bc_*; nothing is written to RAM on an IO or unmapped hit.
// TESTING
//  1 RAM: write 0x0000_0010<=A5A5_0001 (dram_we=1, dram_addr=4); read it back
//    -> bc_cpu_data=A5A5_0001 exactly 1 cycle after the read address.
//  2 IO: write FFFF_0000<=0000_1234 -> led=1234. sw=00FF -> read FFFF_0004 =000000FF
//    (after sync). Read 0x8000_0000 -> 0, with dram_we=0 and no register changed.
//  3 Timer: TCMP=0x10, TCNT=0x0 -> irq=1 once TCNT reaches 0x10; irq stays 1 after wrap.
//    Write 1 to STATUS[0] -> irq=0. W1C in the match cycle -> irq stays 1.
//  4 FIFO: tx_ready=0, push 9 bytes 01..09 -> full=1, count=8, overflow=1, 09 dropped.
//    Then tx_ready=1 -> bytes 01..08 drain in order, one per cycle, and tx_valid then drops.
//  5 Full with simultaneous push+pop -> push accepted, count stays 8, overflow stays 0.
//  6 Assert rst for 1 cycle with FIFO holding 3 bytes and match set
//    -> next cycle tx_valid=0, irq=0, led=0, TCMP=FFFF_FFFF.

Source files
------------

// File: rtl/bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_ctrl_if
// Brief    : CPU/RAM/IO signal bundle for the bus controller.
// Revision : 1.0
// ============================================================================
interface bus_ctrl_if #(
    parameter int RAM_AW = 10,
    parameter int LED_W  = 16,
    parameter int SW_W   = 16
) ();
    logic [31:0]       cpu_bc_addr;
    logic [31:0]       cpu_bc_data;
    logic              cpu_bc_rw;
    logic [31:0]       bc_cpu_data;
    logic [RAM_AW-1:0] dram_addr;
    logic [31:0]       dram_wdata;
    logic              dram_we;
    logic [31:0]       dram_rdata;
    logic [LED_W-1:0]  led;
    logic [SW_W-1:0]   sw;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              irq;

    modport master (
        output cpu_bc_addr, cpu_bc_data, cpu_bc_rw, dram_rdata, sw, tx_ready,
        input  bc_cpu_data, dram_addr, dram_wdata, dram_we, led, tx_data, tx_valid, irq
    );

    modport slave (
        input  cpu_bc_addr, cpu_bc_data, cpu_bc_rw, dram_rdata, sw, tx_ready,
        output bc_cpu_data, dram_addr, dram_wdata, dram_we, led, tx_data, tx_valid, irq
    );
endinterface
`default_nettype wire

// File: rtl/bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_ctrl
// Brief    : Routes CPU accesses to data RAM or an IO page (LED, SW, timer, TX FIFO).
// Revision : 1.0
// ============================================================================
module bus_ctrl #(
    parameter int          RAM_AW  = 10,
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
    parameter int          FIFO_AW = 3,
    parameter int          LED_W   = 16,
    parameter int          SW_W    = 16
) (
    input  logic      clk,
    input  logic      rst,
    bus_ctrl_if.slave bus
);
    localparam int               DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [2:0]       OFF_LED    = 3'd0;
    localparam logic [2:0]       OFF_SW     = 3'd1;
    localparam logic [2:0]       OFF_TCNT   = 3'd2;
    localparam logic [2:0]       OFF_TCMP   = 3'd3;
    localparam logic [2:0]       OFF_STATUS = 3'd4;
    localparam logic [2:0]       OFF_TXDATA = 3'd5;

    logic [SW_W-1:0]    sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [31:0]        tcnt_q, tcnt_d, tcmp_q, tcmp_d;
    logic               match_q, match_d, ovf_q, ovf_d;
    logic [7:0]         fifo_mem_q [DEPTH];
    logic [7:0]         fifo_mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               rd_ram_q, rd_ram_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic        w_ram_hit, w_io_hit, w_pop, w_push, w_push_ok;
    logic [2:0]  w_off;
    logic [31:0] w_status, w_io_rdata;
    logic        w_unused;

    assign w_ram_hit = (bus.cpu_bc_addr[31:RAM_AW+2] == '0);
    assign w_io_hit  = (bus.cpu_bc_addr[31:5] == IO_BASE[31:5]);
    assign w_off     = bus.cpu_bc_addr[4:2];
    assign w_unused  = ^bus.cpu_bc_addr[1:0];

    assign bus.dram_addr  = bus.cpu_bc_addr[RAM_AW+1:2];
    assign bus.dram_wdata = bus.cpu_bc_data;
    assign bus.dram_we    = bus.cpu_bc_rw & w_ram_hit;

    assign bus.tx_valid    = (count_q != '0);
    assign bus.tx_data     = bus.tx_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;
    assign bus.led         = led_q;
    assign bus.irq         = match_q;
    assign bus.bc_cpu_data = rd_ram_q ? bus.dram_rdata : rd_data_q;

    // Pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign w_pop     = bus.tx_valid & bus.tx_ready;
    assign w_push    = bus.cpu_bc_rw & w_io_hit & (w_off == OFF_TXDATA);
    assign w_push_ok = w_push & ((count_q != FULL_CNT) | w_pop);

    always_comb begin
        w_status                 = '0;
        w_status[0]              = match_q;
        w_status[1]              = (count_q == FULL_CNT);
        w_status[2]              = (count_q == '0);
        w_status[3]              = ovf_q;
        w_status[FIFO_AW+4:4]    = count_q;
        case (w_off)
            OFF_LED:    w_io_rdata = 32'(led_q);
            OFF_SW:     w_io_rdata = 32'(sw_sync_q);
            OFF_TCNT:   w_io_rdata = tcnt_q;
            OFF_TCMP:   w_io_rdata = tcmp_q;
            OFF_STATUS: w_io_rdata = w_status;
            default:    w_io_rdata = '0;
        endcase
    end

    always_comb begin
        sw_meta_d  = bus.sw;
        sw_sync_d  = sw_meta_q;
        led_d      = led_q;
        tcnt_d     = tcnt_q + 32'd1;
        tcmp_d     = tcmp_q;
        match_d    = match_q;
        ovf_d      = ovf_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + {{FIFO_AW{1'b0}}, w_push_ok} - {{FIFO_AW{1'b0}}, w_pop};
        rd_ram_d   = w_ram_hit;
        rd_data_d  = w_io_hit ? w_io_rdata : '0;

        if (bus.cpu_bc_rw && w_io_hit) begin
            case (w_off)
                OFF_LED:    led_d  = bus.cpu_bc_data[LED_W-1:0];
                OFF_TCNT:   tcnt_d = bus.cpu_bc_data;
                OFF_TCMP:   tcmp_d = bus.cpu_bc_data;
                OFF_STATUS: begin
                    if (bus.cpu_bc_data[0]) match_d = 1'b0;
                    if (bus.cpu_bc_data[3]) ovf_d   = 1'b0;
                end
                default: ;
            endcase
        end
        // Set sources are applied last so they win over a same-cycle clear.
        if (tcnt_q == tcmp_q)       match_d = 1'b1;
        if (w_push && !w_push_ok)   ovf_d   = 1'b1;

        if (w_push_ok) begin
            fifo_mem_d[wr_ptr_q] = bus.cpu_bc_data[7:0];
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (w_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
            tcnt_q    <= '0;
            tcmp_q    <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_ram_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            led_q     <= led_d;
            tcnt_q    <= tcnt_d;
            tcmp_q    <= tcmp_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_ram_q  <= rd_ram_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset: tx_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end
endmodule
`default_nettype wire

// File: tb/tb_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_ctrl
// Brief    : Randomized and directed checks of bus_ctrl against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_bus_ctrl;
    localparam logic [31:0] IO = 32'hFFFF_0000;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bus_ctrl_if #(.RAM_AW(10), .LED_W(16), .SW_W(16)) bus ();

    bus_ctrl #(
        .RAM_AW(10), .IO_BASE(32'hFFFF_0000), .FIFO_AW(3), .LED_W(16), .SW_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External synchronous RAM, read-before-write.
    logic [31:0] tb_ram [0:1023] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.dram_we) tb_ram[bus.dram_addr] <= bus.dram_wdata;
        bus.dram_rdata <= tb_ram[bus.dram_addr];
    end

    // Behavioural model state
    logic [31:0] mram [0:1023] = '{default: 32'h0};
    logic [15:0] m_led, m_sw1, m_sw2;
    logic [31:0] m_tcnt, m_tcmp, m_rd;
    logic        m_match, m_ovf;
    logic [7:0]  m_q [$];

    function automatic logic [31:0] m_status();
        int n = m_q.size();
        return {24'h0, 4'(n), m_ovf, (n == 0), (n == 8), m_match};
    endfunction

    function automatic logic [57:0] exp_vec();
        logic [7:0] head = (m_q.size() != 0) ? m_q[0] : 8'h00;
        return {m_rd, m_led, m_match, (m_q.size() != 0), head};
    endfunction

    task automatic model_edge();
        logic [31:0] a, d, rd;
        logic        w, rdy, ram, io, pop, push, full;
        logic [2:0]  off;
        a = bus.cpu_bc_addr; d = bus.cpu_bc_data; w = bus.cpu_bc_rw; rdy = bus.tx_ready;
        if (!rst) begin
            m_led = 0; m_sw1 = 0; m_sw2 = 0; m_tcnt = 0; m_tcmp = 32'hFFFF_FFFF;
            m_match = 0; m_ovf = 0; m_rd = 0; m_q.delete();
            return;
        end
        ram = (a < 32'h0000_1000);
        io  = (a >= IO) && (a < IO + 32'h20);
        off = a[4:2];
        rd  = 32'h0;
        if (ram) rd = mram[a[11:2]];
        else if (io) begin
            case (off)
                3'd0: rd = {16'h0, m_led};
                3'd1: rd = {16'h0, m_sw2};
                3'd2: rd = m_tcnt;
                3'd3: rd = m_tcmp;
                3'd4: rd = m_status();
                default: rd = 32'h0;
            endcase
        end
        pop  = (m_q.size() != 0) && rdy;
        push = w && io && (off == 3'd5);
        full = (m_q.size() == 8);
        if (w && ram) mram[a[11:2]] = d;
        if (w && io && off == 3'd0) m_led = d[15:0];
        if (w && io && off == 3'd3) m_tcmp = d;
        if (m_tcnt == m_tcmp)                      m_match = 1'b1;
        else if (w && io && off == 3'd4 && d[0])   m_match = 1'b0;
        if (push && full && !pop)                  m_ovf = 1'b1;
        else if (w && io && off == 3'd4 && d[3])   m_ovf = 1'b0;
        m_tcnt = (w && io && off == 3'd2) ? d : m_tcnt + 32'd1;
        if (pop) void'(m_q.pop_front());
        if (push && (!full || pop)) m_q.push_back(d[7:0]);
        m_sw2 = m_sw1;
        m_sw1 = bus.sw;
        m_rd  = rd;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic rdy);
        bus.cpu_bc_addr = a;
        bus.cpu_bc_data = d;
        bus.cpu_bc_rw   = w;
        bus.tx_ready    = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        total++;
        if ({bus.bc_cpu_data, bus.led, bus.irq, bus.tx_valid, bus.tx_data} !== 58'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {bus.bc_cpu_data, bus.led, bus.irq, bus.tx_valid, bus.tx_data});
        end
        drive(IO + 32'hC, 32'h0, 1'b0, 1'b0); tick();
        total++;
        if (bus.bc_cpu_data !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL reset_tcmp got=%h exp=ffffffff", bus.bc_cpu_data);
        end
        drive(IO + 32'h10, 32'h0, 1'b0, 1'b0); tick();
        total++;
        if (bus.bc_cpu_data !== 32'h4) begin
            bad++; $display("FAIL reset_status got=%h exp=00000004", bus.bc_cpu_data);
        end
    endtask

    task automatic test_ram();
        drive(32'h10, 32'hA5A5_0001, 1'b1, 1'b0);
        #1;
        total++;
        if ({bus.dram_we, bus.dram_addr, bus.dram_wdata} !== {1'b1, 10'd4, 32'hA5A5_0001}) begin
            bad++; $display("FAIL ram_write_port got=%b/%0d/%h exp=1/4/a5a50001", bus.dram_we, bus.dram_addr, bus.dram_wdata);
        end
        tick();
        drive(32'h10, 32'h0, 1'b0, 1'b0); tick();
        total++;
        if (bus.bc_cpu_data !== 32'hA5A5_0001) begin
            bad++; $display("FAIL ram_readback got=%h exp=a5a50001", bus.bc_cpu_data);
        end
    endtask

    task automatic test_io();
        drive(IO, 32'h0000_1234, 1'b1, 1'b0); tick();
        total++;
        if (bus.led !== 16'h1234) begin
            bad++; $display("FAIL io_led got=%h exp=1234", bus.led);
        end
        bus.sw = 16'h00FF;
        drive(32'h0, 32'h0, 1'b0, 1'b0); repeat (2) tick();
        drive(IO + 32'h4, 32'h0, 1'b0, 1'b0); tick();
        total++;
        if (bus.bc_cpu_data !== 32'h0000_00FF) begin
            bad++; $display("FAIL io_sw got=%h exp=000000ff", bus.bc_cpu_data);
        end
        drive(32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #1;
        total++;
        if (bus.dram_we !== 1'b0) begin
            bad++; $display("FAIL unmapped_we got=%b exp=0", bus.dram_we);
        end
        tick();
        drive(32'h8000_0000, 32'h0, 1'b0, 1'b0); tick();
        total++;
        if ({bus.bc_cpu_data, bus.led, bus.tx_valid} !== {32'h0, 16'h1234, 1'b0}) begin
            bad++; $display("FAIL unmapped_read got=%h/%h/%b exp=0/1234/0", bus.bc_cpu_data, bus.led, bus.tx_valid);
        end
    endtask

    task automatic test_timer();
        drive(IO + 32'hC, 32'h10, 1'b1, 1'b0); tick();
        drive(IO + 32'h8, 32'h0, 1'b1, 1'b0); tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (bus.irq !== m_match) begin
                bad++; $display("FAIL timer_count cyc=%0d got=%b exp=%b", i, bus.irq, m_match);
            end
        end
        total++;
        if (bus.irq !== 1'b1) begin bad++; $display("FAIL timer_irq got=%b exp=1", bus.irq); end
        drive(IO + 32'h8, 32'hFFFF_FFFE, 1'b1, 1'b0); tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0); repeat (4) tick();
        total++;
        if (bus.irq !== 1'b1) begin bad++; $display("FAIL timer_wrap got=%b exp=1", bus.irq); end
        drive(IO + 32'h10, 32'h1, 1'b1, 1'b0); tick();
        total++;
        if (bus.irq !== 1'b0) begin bad++; $display("FAIL timer_w1c got=%b exp=0", bus.irq); end
        drive(IO + 32'h8, 32'hE, 1'b1, 1'b0); tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0); repeat (2) tick();
        drive(IO + 32'h10, 32'h1, 1'b1, 1'b0); tick();
        total++;
        if (bus.irq !== 1'b1) begin bad++; $display("FAIL timer_set_wins got=%b exp=1", bus.irq); end
    endtask

    task automatic test_fifo();
        drive(IO + 32'h10, 32'h9, 1'b1, 1'b0); tick();
        for (int i = 1; i <= 9; i++) begin
            drive(IO + 32'h14, 32'(i), 1'b1, 1'b0); tick();
        end
        drive(IO + 32'h10, 32'h0, 1'b0, 1'b0); tick();
        total++;
        if (bus.bc_cpu_data !== 32'h0000_008A) begin
            bad++; $display("FAIL fifo_full_status got=%h exp=0000008a", bus.bc_cpu_data);
        end
        drive(32'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            total++;
            if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'(k)}) begin
                bad++; $display("FAIL fifo_drain k=%0d got=%b/%h exp=1/%h", k, bus.tx_valid, bus.tx_data, 8'(k));
            end
            tick();
        end
        total++;
        if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL fifo_empty got=%b exp=0", bus.tx_valid); end
    endtask

    task automatic test_back_to_back();
        drive(IO + 32'h10, 32'h8, 1'b1, 1'b0); tick();
        for (int i = 0; i < 8; i++) begin
            drive(IO + 32'h14, 32'h11 + 32'(i), 1'b1, 1'b0); tick();
        end
        drive(IO + 32'h14, 32'hAA, 1'b1, 1'b1); tick();
        drive(IO + 32'h10, 32'h0, 1'b0, 1'b0); tick();
        total++;
        if ({bus.bc_cpu_data, bus.tx_data} !== {32'h0000_0082, 8'h12}) begin
            bad++; $display("FAIL full_push_pop got=%h/%h exp=00000082/12", bus.bc_cpu_data, bus.tx_data);
        end
        drive(32'h0, 32'h0, 1'b0, 1'b1); repeat (8) tick();
        total++;
        if ({bus.tx_valid, bus.tx_data} !== exp_vec()[8:0]) begin
            bad++; $display("FAIL full_push_pop_drain got=%h exp=%h", {bus.tx_valid, bus.tx_data}, exp_vec()[8:0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        w;
        int          kind;
        for (int c = 0; c < 400; c++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4)      a = {22'h0, 4'($urandom_range(0, 15)), 2'b00} | 32'h40;
            else if (kind < 9) a = IO + {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            else               a = 32'h0001_0000 | ($urandom() & 32'h7FFF_FFFC);
            d = $urandom();
            if (a[4:3] == 2'b01 && $urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 63));
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.sw = 16'($urandom());
            drive(a, d, w, 1'($urandom_range(0, 3) == 0));
            #1;
            total++;
            if ({bus.dram_we, bus.dram_addr, bus.dram_wdata} !== {w && (a < 32'h1000), a[11:2], d}) begin
                bad++; $display("FAIL rand_dram c=%0d addr=%h got_we=%b", c, a, bus.dram_we);
            end
            tick();
            total++;
            if ({bus.bc_cpu_data, bus.led, bus.irq, bus.tx_valid, bus.tx_data} !== exp_vec()) begin
                bad++; $display("FAIL rand_state c=%0d got=%h exp=%h", c,
                    {bus.bc_cpu_data, bus.led, bus.irq, bus.tx_valid, bus.tx_data}, exp_vec());
            end
        end
    endtask

    task automatic test_midreset();
        drive(IO, 32'h55AA, 1'b1, 1'b0); tick();
        for (int i = 1; i <= 3; i++) begin
            drive(IO + 32'h14, 32'hC0 + 32'(i), 1'b1, 1'b0); tick();
        end
        drive(IO + 32'hC, 32'h30, 1'b1, 1'b0); tick();
        drive(IO + 32'h8, 32'h30, 1'b1, 1'b0); tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0); repeat (2) tick();
        total++;
        if ({bus.irq, bus.tx_valid, bus.led} !== {1'b1, 1'b1, 16'h55AA} || exp_vec() !== {bus.bc_cpu_data, bus.led, bus.irq, bus.tx_valid, bus.tx_data}) begin
            bad++; $display("FAIL midreset_setup got=%b/%b/%h exp=1/1/55aa", bus.irq, bus.tx_valid, bus.led);
        end
        rst = 1'b0; tick(); rst = 1'b1;
        total++;
        if ({bus.bc_cpu_data, bus.led, bus.irq, bus.tx_valid, bus.tx_data} !== 58'h0) begin
            bad++; $display("FAIL midreset_clear got=%h exp=0", {bus.bc_cpu_data, bus.led, bus.irq, bus.tx_valid, bus.tx_data});
        end
        drive(IO + 32'hC, 32'h0, 1'b0, 1'b0); tick();
        total++;
        if ({bus.bc_cpu_data, bus.tx_valid} !== {32'hFFFF_FFFF, 1'b0}) begin
            bad++; $display("FAIL midreset_tcmp got=%h/%b exp=ffffffff/0", bus.bc_cpu_data, bus.tx_valid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.sw = 16'h0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_ram();
        test_io();
        test_timer();
        test_fifo();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
